// File: rtl/alu_issue_stage.sv
// alu_issue_stage: one-deep issue/retire wrapper in front of cv32e40p_alu with a one-entry writeback register.
// Optional EXEC watchdog is built in when ALU_ISSUE_TIMEOUT_EN is defined.
module alu_issue_stage #(
    parameter int OP_W        = 7,
    parameter int RD_W        = 6,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    // Handshakes (decode side and writeback side) are strict valid/ready: a transfer
    // happens on a rising edge where both are 1; a sender keeps payload stable while waiting.
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [OP_W-1:0] in_operator_i,
    input  logic [31:0]     in_op_a_i,
    input  logic [31:0]     in_op_b_i,
    input  logic [31:0]     in_op_c_i,
    input  logic [1:0]      in_vec_mode_i,
    input  logic [RD_W-1:0] in_rd_i,
    output logic            enable_o,
    output logic [OP_W-1:0] operator_o,
    output logic [31:0]     op_a_o,
    output logic [31:0]     op_b_o,
    output logic [31:0]     op_c_o,
    output logic [1:0]      vec_mode_o,
    input  logic [31:0]     alu_result_i,
    input  logic            alu_ready_i,
    output logic            ex_ready_o,
    output logic            wb_valid_o,
    input  logic            wb_ready_i,
    output logic [31:0]     wb_result_o,
    output logic [RD_W-1:0] wb_rd_o,
    output logic            timeout_o
);
    typedef enum logic {S_IDLE = 1'b0, S_EXEC = 1'b1} state_e;

    state_e          state_q, state_d;
    logic [OP_W-1:0] operator_q;
    logic [31:0]     op_a_q, op_b_q, op_c_q;
    logic [1:0]      vec_mode_q;
    logic [RD_W-1:0] rd_q;
    logic            wb_valid_q, wb_valid_d;
    logic [31:0]     wb_result_q;
    logic [RD_W-1:0] wb_rd_q;
    logic            exec, slot_free, done, accept, timeout_hit;

    assign exec       = (state_q == S_EXEC);
    assign slot_free  = !wb_valid_q || wb_ready_i;
    assign done       = exec && alu_ready_i && slot_free;
    // Gating with rst_n keeps decode from handing over an op while reset is held.
    assign in_ready_o = rst_n && (!exec || done);
    assign accept     = in_valid_i && in_ready_o;
    assign ex_ready_o = exec && slot_free;

    assign enable_o    = exec;
    assign operator_o  = operator_q;
    assign op_a_o      = op_a_q;
    assign op_b_o      = op_b_q;
    assign op_c_o      = op_c_q;
    assign vec_mode_o  = vec_mode_q;
    assign wb_valid_o  = wb_valid_q;
    assign wb_result_o = wb_result_q;
    assign wb_rd_o     = wb_rd_q;

`ifdef ALU_ISSUE_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             timeout_q, timeout_d;

    // Counts consecutive EXEC cycles without alu_ready_i; the op is dropped on the limit.
    always_comb begin
        tmo_cnt_d   = '0;
        timeout_d   = timeout_q;
        timeout_hit = 1'b0;
        if (exec && !alu_ready_i) begin
            if (tmo_cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                timeout_hit = 1'b1;
                timeout_d   = 1'b1;
            end else begin
                tmo_cnt_d = tmo_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_q <= '0;
            timeout_q <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout_o = timeout_q;
`else
    assign timeout_hit = 1'b0;
    assign timeout_o   = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        if (accept) begin
            state_d = S_EXEC;
        end else if (done || timeout_hit) begin
            state_d = S_IDLE;
        end
    end

    // A retire in the same cycle as a consume refills the slot without a bubble.
    always_comb begin
        wb_valid_d = wb_valid_q;
        if (done) begin
            wb_valid_d = 1'b1;
        end else if (wb_ready_i) begin
            wb_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            operator_q  <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            op_c_q      <= '0;
            vec_mode_q  <= '0;
            rd_q        <= '0;
            wb_valid_q  <= 1'b0;
            wb_result_q <= '0;
            wb_rd_q     <= '0;
        end else begin
            state_q    <= state_d;
            wb_valid_q <= wb_valid_d;
            if (accept) begin
                operator_q <= in_operator_i;
                op_a_q     <= in_op_a_i;
                op_b_q     <= in_op_b_i;
                op_c_q     <= in_op_c_i;
                vec_mode_q <= in_vec_mode_i;
                rd_q       <= in_rd_i;
            end
            if (done) begin
                wb_result_q <= alu_result_i;
                wb_rd_q     <= rd_q;
            end
        end
    end
endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed cases plus randomized traffic
// against a queue-based reference model; bench also plays the ALU.
module tb_alu_issue_stage;
    localparam logic [6:0] OP_ADD  = 7'b0011000;
    localparam logic [6:0] OP_SUB  = 7'b0011001;
    localparam logic [6:0] OP_DIVU = 7'b0110000;
    localparam logic [6:0] OP_XOR  = 7'b0101111;
`ifdef ALU_ISSUE_TIMEOUT_EN
    localparam int TMO = 8;
    localparam int DIV_LAT = 6;
    localparam int RST_AT = 3;
`else
    localparam int TMO = 64;
    localparam int DIV_LAT = 34;
    localparam int RST_AT = 10;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid_i, in_ready_o;
    logic [6:0]  in_operator_i;
    logic [31:0] in_op_a_i, in_op_b_i, in_op_c_i;
    logic [1:0]  in_vec_mode_i;
    logic [5:0]  in_rd_i;
    logic        enable_o;
    logic [6:0]  operator_o;
    logic [31:0] op_a_o, op_b_o, op_c_o;
    logic [1:0]  vec_mode_o;
    logic [31:0] alu_result_i;
    logic        alu_ready_i, ex_ready_o;
    logic        wb_valid_o, wb_ready_i;
    logic [31:0] wb_result_o;
    logic [5:0]  wb_rd_o;
    logic        timeout_o;

    int checks = 0;
    int errors = 0;
    bit rnd_wb = 1'b0;
    bit alu_hang = 1'b0;

    alu_issue_stage #(.OP_W(7), .RD_W(6), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .in_operator_i(in_operator_i), .in_op_a_i(in_op_a_i), .in_op_b_i(in_op_b_i),
        .in_op_c_i(in_op_c_i), .in_vec_mode_i(in_vec_mode_i), .in_rd_i(in_rd_i),
        .enable_o(enable_o), .operator_o(operator_o), .op_a_o(op_a_o), .op_b_o(op_b_o),
        .op_c_o(op_c_o), .vec_mode_o(vec_mode_o),
        .alu_result_i(alu_result_i), .alu_ready_i(alu_ready_i), .ex_ready_o(ex_ready_o),
        .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i), .wb_result_o(wb_result_o),
        .wb_rd_o(wb_rd_o), .timeout_o(timeout_o)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- ALU stand-in ----------------
    function automatic logic [31:0] alu_fn(input logic [6:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            default: return a ^ b;
        endcase
    endfunction

    function automatic int alu_lat(input logic [6:0] op);
        case (op)
            OP_DIVU: return DIV_LAT;
            OP_SUB:  return 2;
            default: return 0;
        endcase
    endfunction

    int alu_cnt;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) alu_cnt <= 0;
        else if (!enable_o || (alu_ready_i && ex_ready_o)) alu_cnt <= 0;
        else alu_cnt <= alu_cnt + 1;
    end
    assign alu_ready_i  = enable_o && !alu_hang && (alu_cnt >= alu_lat(operator_o));
    assign alu_result_i = alu_ready_i ? alu_fn(operator_o, op_a_o, op_b_o) : 32'hDEAD_BEEF;

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [6:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic [1:0]  vm;
        logic [5:0]  rd;
    } op_t;

    op_t         issue_q[$];
    logic [37:0] exp_q[$];
    int          stall_m = 0;
    bit          tmo_m = 1'b0;
    bit          busy, full, exp_ex, done_m, exp_in;
    op_t         cur;

    // Reference model: the ALU holds at most one op, writeback holds at most one result.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_in_ready", in_ready_o, 0);
            chk("rst_enable", enable_o, 0);
            chk("rst_ex_ready", ex_ready_o, 0);
            chk("rst_wb_valid", wb_valid_o, 0);
            chk("rst_wb_result", wb_result_o, 0);
            chk("rst_wb_rd", wb_rd_o, 0);
            chk("rst_operator", operator_o, 0);
            chk("rst_op_a", op_a_o, 0);
            chk("rst_timeout", timeout_o, 0);
            issue_q.delete();
            exp_q.delete();
            stall_m = 0;
            tmo_m = 1'b0;
        end else begin
            busy   = issue_q.size() != 0;
            full   = exp_q.size() != 0;
            exp_ex = busy && (!full || wb_ready_i);
            done_m = exp_ex && alu_ready_i;
            exp_in = !busy || done_m;
            chk("enable", enable_o, busy);
            chk("ex_ready", ex_ready_o, exp_ex);
            chk("in_ready", in_ready_o, exp_in);
            chk("wb_valid", wb_valid_o, full);
            chk("timeout", timeout_o, tmo_m);
            if (busy) begin
                cur = issue_q[0];
                chk("alu_operator", operator_o, cur.op);
                chk("alu_op_a", op_a_o, cur.a);
                chk("alu_op_b", op_b_o, cur.b);
                chk("alu_op_c", op_c_o, cur.c);
                chk("alu_vec_mode", vec_mode_o, cur.vm);
            end
            if (full) chk("wb_rd_result", {wb_rd_o, wb_result_o}, exp_q[0]);
            if (full && wb_ready_i) void'(exp_q.pop_front());
            if (done_m) begin
                cur = issue_q.pop_front();
                exp_q.push_back({cur.rd, alu_fn(cur.op, cur.a, cur.b)});
                stall_m = 0;
            end else if (busy && !alu_ready_i) begin
                stall_m++;
`ifdef ALU_ISSUE_TIMEOUT_EN
                if (stall_m == TMO) begin
                    void'(issue_q.pop_front());
                    tmo_m = 1'b1;
                    stall_m = 0;
                end
`endif
            end else begin
                stall_m = 0;
            end
            if (in_valid_i && exp_in)
                issue_q.push_back('{op: in_operator_i, a: in_op_a_i, b: in_op_b_i,
                                    c: in_op_c_i, vm: in_vec_mode_i, rd: in_rd_i});
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (rnd_wb) wb_ready_i = ($urandom_range(0, 3) != 0);
        end
    endtask

    task automatic issue(input logic [6:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] c, input logic [1:0] vm, input logic [5:0] rd,
                         output int waits);
        logic rdy;
        waits = 0;
        in_valid_i = 1'b1;
        in_operator_i = op;
        in_op_a_i = a;
        in_op_b_i = b;
        in_op_c_i = c;
        in_vec_mode_i = vm;
        in_rd_i = rd;
        forever begin
            @(negedge clk);
            rdy = in_ready_o;
            @(posedge clk);
            #1;
            if (rnd_wb) wb_ready_i = ($urandom_range(0, 3) != 0);
            if (rdy) break;
            waits++;
            if (waits > 300) begin
                checks++;
                errors++;
                $display("FAIL issue_wait actual=no_accept required=accept_within_300 at %0t", $time);
                break;
            end
        end
        in_valid_i = 1'b0;
    endtask

    task automatic wait_wb();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (wb_valid_o) return;
        end
        checks++;
        errors++;
        $display("FAIL wb_wait actual=no_wb_valid required=wb_valid_within_200 at %0t", $time);
    endtask

    // ---------------- stimulus ----------------
    int w1, w2;
    logic [6:0] rop;
    initial begin
        rst_n = 1'b0;
        in_valid_i = 1'b0;
        in_operator_i = '0;
        in_op_a_i = '0;
        in_op_b_i = '0;
        in_op_c_i = '0;
        in_vec_mode_i = '0;
        in_rd_i = '0;
        wb_ready_i = 1'b1;
        tick(3);
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", in_ready_o, 1);
        chk("post_rst_enable", enable_o, 0);

        // single ADD: result appears two cycles after accept
        issue(OP_ADD, 5, 7, 0, 0, 3, w1);
        @(negedge clk);
        chk("t1_enable", enable_o, 1);
        chk("t1_wb_not_yet", wb_valid_o, 0);
        @(negedge clk);
        chk("t1_wb_valid", wb_valid_o, 1);
        chk("t1_result", wb_result_o, 12);
        chk("t1_rd", wb_rd_o, 3);
        tick(2);

        // back-to-back ADDs with no bubble
        issue(OP_ADD, 1, 2, 0, 0, 4, w1);
        issue(OP_ADD, 3, 4, 0, 0, 5, w2);
        chk("t2_first_wait", w1, 0);
        chk("t2_second_wait", w2, 0);
        @(negedge clk);
        chk("t2_result_a", {wb_valid_o, wb_rd_o, wb_result_o}, {1'b1, 6'd4, 32'd3});
        @(negedge clk);
        chk("t2_result_b", {wb_valid_o, wb_rd_o, wb_result_o}, {1'b1, 6'd5, 32'd7});
        tick(2);

        // multi-cycle DIVU stalls decode
        issue(OP_DIVU, 100, 7, 0, 0, 6, w1);
        repeat (3) begin
            @(negedge clk);
            chk("t3_in_ready_stall", in_ready_o, 0);
            chk("t3_op_a_stable", op_a_o, 100);
        end
        wait_wb();
        chk("t3_result", wb_result_o, 14);
        chk("t3_rd", wb_rd_o, 6);
        tick(2);

        // writeback backpressure holds the ALU result
        wb_ready_i = 1'b0;
        issue(OP_ADD, 0, 1, 0, 0, 7, w1);
        issue(OP_ADD, 9, 1, 0, 0, 8, w2);
        @(negedge clk);
        chk("t4_ex_ready_blocked", ex_ready_o, 0);
        chk("t4_held", {wb_valid_o, wb_rd_o, wb_result_o}, {1'b1, 6'd7, 32'd1});
        tick(2);
        @(negedge clk);
        chk("t4_still_held", wb_result_o, 1);
        chk("t4_in_ready_blocked", in_ready_o, 0);
        tick(1);
        wb_ready_i = 1'b1;
        @(negedge clk);
        chk("t4_ex_ready_free", ex_ready_o, 1);
        chk("t4_consumed_first", wb_result_o, 1);
        @(negedge clk);
        chk("t4_second", {wb_valid_o, wb_rd_o, wb_result_o}, {1'b1, 6'd8, 32'd10});
        tick(2);

        // asynchronous reset in the middle of a DIVU
        issue(OP_DIVU, 1000, 3, 0, 0, 9, w1);
        tick(RST_AT);
        rst_n = 1'b0;
        #1;
        chk("t5_enable_dropped", enable_o, 0);
        chk("t5_wb_dropped", wb_valid_o, 0);
        chk("t5_in_ready_rst", in_ready_o, 0);
        tick(2);
        rst_n = 1'b1;
        #1;
        chk("t5_in_ready_after", in_ready_o, 1);
        issue(OP_ADD, 2, 2, 0, 0, 10, w1);
        wait_wb();
        chk("t5_result", {wb_rd_o, wb_result_o}, {6'd10, 32'd4});
        tick(2);

`ifdef ALU_ISSUE_TIMEOUT_EN
        // watchdog drops a stuck op
        alu_hang = 1'b1;
        issue(OP_ADD, 5, 5, 0, 0, 11, w1);
        for (int k = 0; k < TMO; k++) begin
            @(negedge clk);
            chk("t6_exec", {enable_o, timeout_o}, 2'b10);
        end
        @(negedge clk);
        chk("t6_timeout", {enable_o, timeout_o, wb_valid_o, in_ready_o}, 4'b0101);
        tick(1);
        alu_hang = 1'b0;
        tick(3);
        chk("t6_sticky", timeout_o, 1);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        #1;
        chk("t6_cleared", timeout_o, 0);
        tick(1);
`endif

        // randomized traffic with random writeback backpressure
        rnd_wb = 1'b1;
        for (int i = 0; i < 300; i++) begin
            tick($urandom_range(0, 2));
            case ($urandom_range(0, 9))
                0:       rop = OP_DIVU;
                1, 2:    rop = OP_SUB;
                3, 4:    rop = OP_XOR;
                default: rop = OP_ADD;
            endcase
            issue(rop, $urandom, $urandom_range(0, 40), $urandom, 2'($urandom_range(0, 3)),
                  6'($urandom_range(0, 63)), w1);
        end
        rnd_wb = 1'b0;
        wb_ready_i = 1'b1;
        tick(DIV_LAT + 10);
        @(negedge clk);
        chk("drain_empty", issue_q.size() + exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
